alu_mul_sequencer: RTL and testbench
====================================

// Module: alu_mul_sequencer
// PURPOSE
//  Multi-cycle shift-add multiplier controller. It drives a shared external 32-bit ALU instance (add op 010,
//  sub op 110) to form a 2*WIDTH product over WIDTH iterations, one ALU pass per clock.
//  Sits between the datapath control unit (start/done handshake) and the ALU operand/op muxes.
// PARAMETERS
//  WIDTH   32      operand width; must match the ALU width
//  OP_ADD  3'b010  alu_op code for add
//  OP_SUB  3'b110  alu_op code for subtract (used only with SIGNED_MUL_EN)
//  OP_IDLE 3'b000  alu_op code driven when not running (AND, operands zero)
// PORTS
//  clk         in  1        rising-edge clock; the block's only clock
//  rst         in  1        synchronous, active-high reset
//  start       in  1        request; sampled only while busy=0
//  mcand       in  WIDTH    multiplicand, captured when start is accepted
//  mplier      in  WIDTH    multiplier, captured when start is accepted
//  busy        out 1        high from the cycle after acceptance until done
//  done        out 1        one-cycle pulse; product valid from this cycle on
//  product_hi  out WIDTH    upper half of the result, held until the next accepted start
//  product_lo  out WIDTH    lower half of the result
//  alu_a       out WIDTH    ALU operand 1 (accumulator hi)
//  alu_b       out WIDTH    ALU operand 2 (mcand or 0)
//  alu_op      out 3        ALU op code
//  alu_result  in  WIDTH    ALU result, combinational from alu_a/alu_b/alu_op
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, product_hi, product_lo, count and alu_a/alu_b all 0; alu_op=OP_IDLE.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE/DONE + start: capture mcand; set acc_hi=0 and acc_lo=mplier; count=0; go to RUN.
//   A start in DONE is accepted; done still pulses that cycle.
//  RUN, each cycle:
//   - drive alu_a=acc_hi, alu_b = acc_lo[0] ? mcand : 0, alu_op=OP_ADD.
//   - cout = (a[31]&b[31]) | ((a[31]|b[31]) & ~alu_result[31]). The ALU has no carry output.
//   - {acc_hi,acc_lo} <= {cout, alu_result, acc_lo[WIDTH-1:1]}.
//   - count++.
//   - When count==WIDTH-1, go to DONE.
//  DONE: done=1 for exactly one cycle; product_hi/lo <= acc. The ALU is released: alu_op=OP_IDLE, a=b=0.
//  Latency: start sampled at edge N, done high in cycle N+WIDTH+1; fixed and data-independent.
//  busy=1 only in RUN. A start while busy is ignored and must not corrupt the operation in flight.
//  Outside RUN, ALU outputs are OP_IDLE/0/0 so the ALU can be shared by other masters.
//  Reset mid-RUN: same as power-on reset; no done pulse; the previous product is cleared to 0.
//  Boundaries: mcand=0 or mplier=0 -> product 0. All-ones x all-ones must propagate cout on every iteration.
// CONFIGURATION
//  SIGNED_MUL_EN defined: adds input port is_signed (1 bit, captured with the operands).
//   When is_signed=1, operands are two's complement:
//   - the final iteration (count==WIDTH-1) uses OP_SUB when acc_lo[0]=1;
//   - the shift-in bit is the true sign, alu_result[WIDTH-1] ^ ovf, where ovf is the signed overflow of that op.
//   When is_signed=0, behaviour is identical to the unsigned build.
//  SIGNED_MUL_EN undefined: no is_signed port; unsigned only; OP_SUB is never driven.
// STRUCTURE
//  Shared package alu_pkg: ALU op code constants (AND 000, OR 001, ADD 010, SUB 110, XOR 111),
//  WIDTH default, and the FSM state enum {IDLE, RUN, DONE}.
//  One natural sub-module, mul_carry_calc: cout/ovf from a, b, result and op; combinational.
//  Counter and accumulator stay in the top module.
// TESTING
//  1. mcand=7, mplier=6, start 1 cycle -> done at N+33; product_hi=0, product_lo=42; busy high 32 cycles.
//  2. 0xFFFFFFFF x 0xFFFFFFFF -> product_hi=0xFFFFFFFE, product_lo=0x00000001.
//  3. 0x80000000 x 2 -> hi=1, lo=0.
//     Then pulse start with other operands at cycle N+10 -> ignored; result and done timing unchanged.
//  4. rst high at N+15 of a run -> next cycle busy=0, done=0, product=0, alu_op=000.
//     A new start after that completes normally.
//  5. start held high through DONE -> back-to-back runs.
//     Second run uses the operands present in the DONE cycle; exactly one done pulse per run.
//  6. (SIGNED_MUL_EN) is_signed=1: -1 x -1 -> hi=0, lo=1; -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//     is_signed=0: 0xFFFFFFFF x 0xFFFFFFFF matches test 2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, default datapath width and the multiply-sequencer state encoding.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SUB = 3'b110;
    localparam logic [2:0] ALU_OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_carry_calc.sv
// Recovers carry-out and signed overflow of the shared ALU from operand/result sign bits,
// since the ALU itself exposes no flags. Subtract is treated as a + ~b + 1.
module mul_carry_calc
    import alu_pkg::*;
#(
    parameter logic [2:0] OP_SUB = ALU_OP_SUB
) (
    input  logic       a_msb,
    input  logic       b_msb,
    input  logic       r_msb,
    input  logic [2:0] op,
    output logic       cout_c,
    output logic       ovf_c
);

    logic b_eff;

    always_comb begin
        b_eff  = (op == OP_SUB) ? ~b_msb : b_msb;
        cout_c = (a_msb & b_eff) | ((a_msb | b_eff) & ~r_msb);
        ovf_c  = (a_msb == b_eff) & (r_msb != a_msb);
    end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller that borrows an external ALU for one add per clock.
// Optional signed mode (two's complement, final-iteration subtract) under `SIGNED_MUL_EN.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = ALU_WIDTH,
    parameter logic [2:0]  OP_ADD  = ALU_OP_ADD,
    parameter logic [2:0]  OP_SUB  = ALU_OP_SUB,
    parameter logic [2:0]  OP_IDLE = ALU_OP_AND
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
`ifdef SIGNED_MUL_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] RUN  = 2'(ST_RUN);
    localparam logic [1:0] DONE = 2'(ST_DONE);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;

    logic             busy_d, done_d;
    logic [WIDTH-1:0] product_hi_d, product_lo_d;
    logic [WIDTH-1:0] alu_a_d, alu_b_d;
    logic [2:0]       alu_op_d;

    logic accept;
    logic cout, ovf, shift_in;
    logic signed_q, signed_d;

    assign accept = start && (state_q != RUN);

`ifdef SIGNED_MUL_EN
    assign signed_d = accept ? is_signed : signed_q;

    always_ff @(posedge clk) begin
        if (rst) signed_q <= 1'b0;
        else     signed_q <= signed_d;
    end
`else
    assign signed_q = 1'b0;
    assign signed_d = 1'b0;
`endif

    mul_carry_calc #(
        .OP_SUB (OP_SUB)
    ) u_carry (
        .a_msb  (alu_a[WIDTH-1]),
        .b_msb  (alu_b[WIDTH-1]),
        .r_msb  (alu_result[WIDTH-1]),
        .op     (alu_op),
        .cout_c (cout),
        .ovf_c  (ovf)
    );

    // Unsigned: shift in the carry. Signed: shift in the true sign of the sum.
    assign shift_in = signed_q ? (alu_result[WIDTH-1] ^ ovf) : cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            mcand_q    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            product_hi <= '0;
            product_lo <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= OP_IDLE;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            mcand_q    <= mcand_d;
            busy       <= busy_d;
            done       <= done_d;
            product_hi <= product_hi_d;
            product_lo <= product_lo_d;
            alu_a      <= alu_a_d;
            alu_b      <= alu_b_d;
            alu_op     <= alu_op_d;
        end
    end

    // ALU drive registers are preloaded with the next iteration's operands so they line
    // up with the accumulator in the cycle the ALU result is consumed.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        acc_hi_d     = acc_hi_q;
        acc_lo_d     = acc_lo_q;
        mcand_d      = mcand_q;
        product_hi_d = product_hi;
        product_lo_d = product_lo;
        alu_a_d      = '0;
        alu_b_d      = '0;
        alu_op_d     = OP_IDLE;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d  = RUN;
                    count_d  = '0;
                    acc_hi_d = '0;
                    acc_lo_d = mplier;
                    mcand_d  = mcand;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_hi_d = {shift_in, alu_result[WIDTH-1:1]};
                acc_lo_d = {alu_result[0], acc_lo_q[WIDTH-1:1]};
                count_d  = count_q + CW'(1);
                if (count_q == LAST) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);

        if (state_d == DONE) begin
            product_hi_d = acc_hi_d;
            product_lo_d = acc_lo_d;
        end

        if (state_d == RUN) begin
            alu_a_d  = acc_hi_d;
            alu_b_d  = acc_lo_d[0] ? mcand_d : '0;
            alu_op_d = (signed_d && (count_d == LAST) && acc_lo_d[0]) ? OP_SUB : OP_ADD;
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a behavioural model of the shared ALU.
module tb_alu_mul_sequencer;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] mcand, mplier;
`ifdef SIGNED_MUL_EN
    logic         is_signed;
`endif
    logic         busy, done;
    logic [W-1:0] product_hi, product_lo;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_op;

    int passed = 0;
    int total  = 0;
    logic [2*W-1:0] exp_q[$];

    always #5 clk = ~clk;

    alu_mul_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mcand      (mcand),
        .mplier     (mplier),
`ifdef SIGNED_MUL_EN
        .is_signed  (is_signed),
`endif
        .busy       (busy),
        .done       (done),
        .product_hi (product_hi),
        .product_lo (product_lo),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    always_comb begin
        case (alu_op)
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b010:  alu_result = alu_a + alu_b;
            3'b110:  alu_result = alu_a - alu_b;
            3'b111:  alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
    end

    // Drive one accepted start and record the reference product.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        logic signed [2*W-1:0] sa, sb;
        mcand  = a;
        mplier = b;
`ifdef SIGNED_MUL_EN
        is_signed = s;
`endif
        if (s) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            exp_q.push_back(sa * sb);
        end else begin
            exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Bounded wait for done; optionally pulse a stray start at iteration pulse_at.
    task automatic wait_done(input int pulse_at, output int cyc, output int bc, output bit ok);
        cyc = 0;
        bc  = busy ? 1 : 0;
        ok  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i == pulse_at) begin
                start  = 1'b1;
                mcand  = $urandom;
                mplier = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (busy) bc++;
            if (done) begin
                cyc = i;
                ok  = 1'b1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        mcand = '0;
        mplier = '0;
`ifdef SIGNED_MUL_EN
        is_signed = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_flags busy/done=%b required 00", {busy, done});
        else passed++;
        total++;
        if ({product_hi, product_lo} !== 64'd0) $display("FAIL reset_product got %h required 0", {product_hi, product_lo});
        else passed++;
        total++;
        if ({alu_op, alu_a, alu_b} !== {3'b000, 64'd0}) $display("FAIL reset_alu op=%b a=%h b=%h required 000/0/0", alu_op, alu_a, alu_b);
        else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int cyc, bc;
        bit ok;
        logic [2*W-1:0] exp;
        launch(32'd7, 32'd6, 1'b0);
        total++;
        if (busy !== 1'b1 || alu_op !== 3'b010) $display("FAIL basic_run_start busy=%b op=%b required 1/010", busy, alu_op);
        else passed++;
        wait_done(0, cyc, bc, ok);
        exp = exp_q.pop_front();
        total++;
        if (!ok || cyc != 32) $display("FAIL basic_latency got %0d required 32", cyc);
        else passed++;
        total++;
        if (bc != 32) $display("FAIL basic_busy_cycles got %0d required 32", bc);
        else passed++;
        total++;
        if ({product_hi, product_lo} !== exp) $display("FAIL basic_product got %h required %h", {product_hi, product_lo}, exp);
        else passed++;
        total++;
        if ({alu_op, alu_a, alu_b} !== {3'b000, 64'd0}) $display("FAIL basic_alu_release op=%b a=%h b=%h required 000/0/0", alu_op, alu_a, alu_b);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || {product_hi, product_lo} !== exp) $display("FAIL basic_done_pulse done=%b product=%h required 0/%h", done, {product_hi, product_lo}, exp);
        else passed++;
    endtask

    task automatic test_patterns();
        logic [W-1:0] av[6];
        logic [W-1:0] bv[6];
        int cyc, bc;
        bit ok;
        logic [2*W-1:0] exp;
        av = '{32'hFFFF_FFFF, 32'd0, 32'h0000_DEAD, 32'h1234_5678, 32'h8000_0001, $urandom};
        bv = '{32'hFFFF_FFFF, 32'h0012_3456, 32'd0, 32'h9ABC_DEF0, 32'hFFFF_FFFF, $urandom};
        for (int k = 0; k < 6; k++) begin
            launch(av[k], bv[k], 1'b0);
            wait_done(0, cyc, bc, ok);
            exp = exp_q.pop_front();
            total++;
            if (!ok || cyc != 32 || {product_hi, product_lo} !== exp)
                $display("FAIL pattern_%0d product=%h latency=%0d required %h/32", k, {product_hi, product_lo}, cyc, exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignored_start();
        int cyc, bc;
        bit ok;
        logic [2*W-1:0] exp;
        launch(32'h8000_0000, 32'd2, 1'b0);
        wait_done(10, cyc, bc, ok);
        exp = exp_q.pop_front();
        total++;
        if (!ok || cyc != 32) $display("FAIL ignored_start_latency got %0d required 32", cyc);
        else passed++;
        total++;
        if ({product_hi, product_lo} !== exp) $display("FAIL ignored_start_product got %h required %h", {product_hi, product_lo}, exp);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL ignored_start_idle busy/done=%b%b required 00", busy, done);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        int cyc, bc;
        bit ok;
        logic [2*W-1:0] exp;
        launch(32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0);
        exp = exp_q.pop_front();
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy, done} !== 2'b00 || alu_op !== 3'b000) $display("FAIL midreset_ctrl busy/done=%b%b op=%b required 00/000", busy, done, alu_op);
        else passed++;
        total++;
        if ({product_hi, product_lo} !== 64'd0) $display("FAIL midreset_product got %h required 0", {product_hi, product_lo});
        else passed++;
        rst = 1'b0;
        launch(32'd123456, 32'd789, 1'b0);
        wait_done(0, cyc, bc, ok);
        exp = exp_q.pop_front();
        total++;
        if (!ok || cyc != 32 || {product_hi, product_lo} !== exp)
            $display("FAIL midreset_recover product=%h latency=%0d required %h/32", {product_hi, product_lo}, cyc, exp);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int first_at = 0;
        int second_at = 0;
        logic [2*W-1:0] exp;
        launch(32'd1000, 32'd3000, 1'b0);
        start  = 1'b1;
        mcand  = 32'h5555_5555;
        mplier = 32'h7777_7777;
        for (int i = 1; i <= 80 && pulses < 2; i++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                exp = exp_q.pop_front();
                total++;
                if ({product_hi, product_lo} !== exp) $display("FAIL b2b_product_%0d got %h required %h", pulses, {product_hi, product_lo}, exp);
                else passed++;
                if (pulses == 1) begin
                    first_at = i;
                    mcand  = 32'hFEDC_BA98;
                    mplier = 32'h0000_0F0F;
                    exp_q.push_back({32'd0, mcand} * {32'd0, mplier});
                end else begin
                    second_at = i;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        total++;
        if (pulses != 2 || first_at != 32 || second_at != 65)
            $display("FAIL b2b_timing pulses=%0d at %0d,%0d required 2 at 32,65", pulses, first_at, second_at);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL b2b_single_pulse done/busy=%b%b required 00", done, busy);
        else passed++;
    endtask

`ifdef SIGNED_MUL_EN
    task automatic test_signed();
        logic [W-1:0] av[3];
        logic [W-1:0] bv[3];
        bit sv[3];
        int cyc, bc;
        bit ok;
        logic [2*W-1:0] exp;
        av = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        bv = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF};
        sv = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            launch(av[k], bv[k], sv[k]);
            wait_done(0, cyc, bc, ok);
            exp = exp_q.pop_front();
            total++;
            if (!ok || {product_hi, product_lo} !== exp)
                $display("FAIL signed_%0d got %h required %h", k, {product_hi, product_lo}, exp);
            else passed++;
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_ignored_start();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SIGNED_MUL_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
